icache: RTL

Direct-mapped, word-line instruction cache directly upstream of the fetch stage. It answers fetch's single-cycle `instEn`/`instAddr` request with a combinational `hit`/`cacheInst`. On a miss it fills the line from the byte-wide main RAM through the memory arbiter, then returns the word on `memInstOutEn`/`memInst`. Fetch consumes either return path identically.

---
 rtl/icache_pkg.sv | 10 +
 rtl/icache_array.sv | 40 ++++
 rtl/icache.sv | 108 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared bus widths, idle bus values and fill FSM state encodings for the instruction cache
package icache_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic Enable = 1'b1;
  localparam logic Disable = 1'b0;
  localparam logic [InstAddrBus-1:0] addrFree = '0;
  localparam logic [InstBus-1:0] dataFree = '0;
  typedef enum logic {ICacheIdle, ICacheFill} state_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: tag/data/valid storage, asynchronous read, synchronous write, valid cleared by rst
// Ports:
//   clk, rst              clock and synchronous active-high reset (clears every valid bit)
//   i_rd_idx              read index, combinational o_valid/o_tag/o_data
//   i_we, i_wr_idx,
//   i_wr_tag, i_wr_data   line write (ignored while rst is high)
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 128,
  parameter int TAG_W = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] i_rd_idx,
  input  logic                     i_we,
  input  logic [$clog2(LINES)-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]         i_wr_tag,
  input  logic [InstBus-1:0]       i_wr_data,
  output logic                     o_valid,
  output logic [TAG_W-1:0]         o_tag,
  output logic [InstBus-1:0]       o_data
);
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [InstBus-1:0] r_data [LINES];
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[i_wr_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_we && !rst) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end
  assign o_valid = r_valid[i_rd_idx];
  assign o_tag = r_tag[i_rd_idx];
  assign o_data = r_data[i_rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache; misses fill from byte-wide RAM through the arbiter
// Macro ICACHE_EN builds the tag/data/valid arrays; without it hit and cacheInst are 0 and every request fills.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instEn, instAddr         fetch request pulse and word-aligned address
//   hit, cacheInst           combinational hit and line data
//   memInstOutEn, memInst    registered fill-complete pulse and assembled word
//   memReq, memAddr          registered RAM request and byte address
//   memGrant, memData        arbiter grant, RAM byte for the address issued one cycle earlier
module icache
  import icache_pkg::*;
#(
  parameter int LINES = 128,
  parameter int ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instEn,
  input  logic [InstAddrBus-1:0] instAddr,
  output logic                   hit,
  output logic [InstBus-1:0]     cacheInst,
  output logic                   memInstOutEn,
  output logic [InstBus-1:0]     memInst,
  output logic                   memReq,
  output logic [InstAddrBus-1:0] memAddr,
  input  logic                   memGrant,
  input  logic [7:0]             memData
);
  state_t r_state;
  logic [InstAddrBus-1:2] r_miss_addr;
  logic [1:0] r_issue;
  logic [1:0] r_rcv;
  logic r_pend;
  logic [23:0] r_buf;
  logic w_fill_done;
  logic [InstBus-1:0] w_word;
  logic w_unused;
  assign w_unused = ^instAddr[1:0];
  // bytes 0..2 are shifted in from the top, byte 3 completes the word straight from memData
  assign w_word = {memData, r_buf};
  assign w_fill_done = (r_state == ICacheFill) && r_pend && (r_rcv == 2'd3);
`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic w_valid;
  logic [TAG_W-1:0] w_tag;
  icache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk(clk),
    .rst(rst),
    .i_rd_idx(instAddr[IDX_W+1:2]),
    .i_we(w_fill_done),
    .i_wr_idx(r_miss_addr[IDX_W+1:2]),
    .i_wr_tag(r_miss_addr[ADDR_W-1:IDX_W+2]),
    .i_wr_data(w_word),
    .o_valid(w_valid),
    .o_tag(w_tag),
    .o_data(cacheInst)
  );
  // gated by instEn because fetch samples hit every cycle
  assign hit = instEn & w_valid & (w_tag == instAddr[ADDR_W-1:IDX_W+2]);
`else
  assign hit = Disable;
  assign cacheInst = dataFree;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ICacheIdle;
      memReq <= Disable;
      memAddr <= addrFree;
      memInstOutEn <= Disable;
      memInst <= dataFree;
      r_miss_addr <= '0;
      r_issue <= '0;
      r_rcv <= '0;
      r_pend <= Disable;
      r_buf <= '0;
    end else begin
      memInstOutEn <= Disable;
      // a granted issue returns its byte in the following cycle regardless of grant then
      r_pend <= memReq & memGrant;
      if (r_state == ICacheIdle) begin
        if (instEn & ~hit) begin
          r_state <= ICacheFill;
          r_miss_addr <= instAddr[InstAddrBus-1:2];
          r_issue <= '0;
          r_rcv <= '0;
          memReq <= Enable;
          memAddr <= {instAddr[InstAddrBus-1:2], 2'd0};
        end
      end else begin
        if (memReq & memGrant) begin
          r_issue <= r_issue + 2'd1;
          memReq <= r_issue != 2'd3;
          memAddr <= r_issue == 2'd3 ? addrFree : {r_miss_addr, r_issue + 2'd1};
        end
        if (r_pend) begin
          r_rcv <= r_rcv + 2'd1;
          r_buf <= {memData, r_buf[23:8]};
        end
        if (w_fill_done) begin
          memInst <= w_word;
          memInstOutEn <= Enable;
          r_state <= ICacheIdle;
        end
      end
    end
  end
endmodule
